// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/allow-in handshake, flush and bubble counter.
// Define PIPE_STAGE_SKID_EN to build the two-entry skid version with a registered in_allow_in.
module pipe_stage_reg #(
  parameter int DATA_W = 160,
  parameter int EXC_W  = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cancel,
  input  logic              in_valid,
  output logic              in_allow_in,
  input  logic [DATA_W-1:0] in_data,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic              in_delay,
  output logic              out_valid,
  input  logic              out_allow_in,
  output logic [DATA_W-1:0] out_data,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_delay,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int ENT_W = DATA_W + EXC_W + 1;

  logic [ENT_W-1:0] in_ent;
  logic [ENT_W-1:0] main_q, main_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] bubble_q;
  logic             accept;
  logic             drain;

  assign in_ent = {in_delay, in_exc, in_data};
  assign {out_delay, out_exc, out_data} = main_q;
  assign out_valid  = valid_q;
  assign bubble_cnt = bubble_q;
  assign drain      = valid_q & out_allow_in;

`ifdef PIPE_STAGE_SKID_EN
  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ENT_W-1:0] skid_q, skid_d;
  logic             allow_q;

  assign in_allow_in = allow_q;
  assign accept      = in_valid & allow_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (cancel) begin
      state_d = S_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d = S_ONE;
            main_d  = in_ent;
          end
        end
        S_ONE: begin
          if (accept && drain) begin
            main_d = in_ent;
          end else if (accept) begin
            state_d = S_TWO;
            skid_d  = in_ent;
          end else if (drain) begin
            state_d = S_EMPTY;
            main_d  = '0;
          end
        end
        S_TWO: begin
          // allow_q is low here, so only a drain can move the state
          if (drain) begin
            state_d = S_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
    valid_d = (state_d != S_EMPTY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_EMPTY;
      skid_q  <= '0;
      allow_q <= 1'b1;
    end else begin
      state_q <= state_d;
      skid_q  <= skid_d;
      allow_q <= (state_d != S_TWO);
    end
  end
`else
  assign in_allow_in = ~valid_q | out_allow_in;
  assign accept      = in_valid & in_allow_in;

  always_comb begin
    valid_d = valid_q;
    main_d  = main_q;
    if (cancel) begin
      valid_d = 1'b0;
      main_d  = '0;
    end else if (accept) begin
      valid_d = 1'b1;
      main_d  = in_ent;
    end else if (drain) begin
      valid_d = 1'b0;
      main_d  = '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q   <= '0;
      valid_q  <= 1'b0;
      bubble_q <= '0;
    end else begin
      main_q  <= main_d;
      valid_q <= valid_d;
      // Counts idle cycles where downstream was ready; flush does not clear it
      if (out_allow_in && !valid_q && !(&bubble_q))
        bubble_q <= bubble_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: stream, backpressure, cancel, bubble saturation, async reset.
// Covers both builds; the backpressure section follows PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
  localparam int DATA_W = 32;
  localparam int EXC_W  = 4;
  localparam int CNT_W  = 3;

  logic              clk;
  logic              reset;
  logic              cancel;
  logic              in_valid;
  logic              in_allow_in;
  logic [DATA_W-1:0] in_data;
  logic [EXC_W-1:0]  in_exc;
  logic              in_delay;
  logic              out_valid;
  logic              out_allow_in;
  logic [DATA_W-1:0] out_data;
  logic [EXC_W-1:0]  out_exc;
  logic              out_delay;
  logic [CNT_W-1:0]  bubble_cnt;

  int total = 0;
  int bad   = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .EXC_W(EXC_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .cancel       (cancel),
    .in_valid     (in_valid),
    .in_allow_in  (in_allow_in),
    .in_data      (in_data),
    .in_exc       (in_exc),
    .in_delay     (in_delay),
    .out_valid    (out_valid),
    .out_allow_in (out_allow_in),
    .out_data     (out_data),
    .out_exc      (out_exc),
    .out_delay    (out_delay),
    .bubble_cnt   (bubble_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; cancel = 1'b0; in_valid = 1'b0; in_data = '0;
    in_exc = '0; in_delay = 1'b0; out_allow_in = 1'b0;

    // reset state
    #2;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_bubble", 64'(bubble_cnt), 64'd0);
    check("rst_allow", 64'(in_allow_in), 64'd1);

    // stream 1,2,3 with downstream always ready
    #10;
    reset = 1'b1; out_allow_in = 1'b1; in_valid = 1'b1; in_data = 32'd1;
    tick();
    check("stream_d1", 64'(out_data), 64'd1);
    check("stream_v1", 64'(out_valid), 64'd1);
    check("stream_bub1", 64'(bubble_cnt), 64'd1);
    in_data = 32'd2;
    tick();
    check("stream_d2", 64'(out_data), 64'd2);
    in_data = 32'd3;
    tick();
    check("stream_d3", 64'(out_data), 64'd3);
    check("stream_bub3", 64'(bubble_cnt), 64'd1);
    in_valid = 1'b0;
    tick();
    check("drain_valid", 64'(out_valid), 64'd0);
    check("drain_zero", 64'(out_data), 64'd0);
    check("drain_bub", 64'(bubble_cnt), 64'd1);

    // backpressure; bubble becomes 2 during the 0xA load cycle
    in_valid = 1'b1; in_data = 32'hA;
    tick();
    check("bp_loadA", 64'(out_data), 64'hA);
`ifdef PIPE_STAGE_SKID_EN
    in_data = 32'hB; out_allow_in = 1'b0;
    tick();
    check("skid_allow0", 64'(in_allow_in), 64'd0);
    check("skid_outA", 64'(out_data), 64'hA);
    in_valid = 1'b0; out_allow_in = 1'b1;
    tick();
    check("skid_outB", 64'(out_data), 64'hB);
    check("skid_validB", 64'(out_valid), 64'd1);
    check("skid_allow1", 64'(in_allow_in), 64'd1);
    tick();
    check("skid_empty", 64'(out_valid), 64'd0);
    check("skid_empty_d", 64'(out_data), 64'd0);
    check("skid_bub", 64'(bubble_cnt), 64'd2);
`else
    in_valid = 1'b0; out_allow_in = 1'b0;
    #1;
    check("nsk_allow0", 64'(in_allow_in), 64'd0);
    tick();
    check("nsk_hold", 64'(out_data), 64'hA);
    check("nsk_hold_v", 64'(out_valid), 64'd1);
    out_allow_in = 1'b1;
    #1;
    check("nsk_allow1", 64'(in_allow_in), 64'd1);
    tick();
    check("nsk_empty", 64'(out_valid), 64'd0);
    check("nsk_bub", 64'(bubble_cnt), 64'd2);
`endif
    out_allow_in = 1'b0;

    // load an entry with flags, then cancel alongside a new payload
    in_valid = 1'b1; in_data = 32'h77; in_exc = 4'b0001; in_delay = 1'b1;
    tick();
    check("flag_data", 64'(out_data), 64'h77);
    check("flag_exc", 64'(out_exc), 64'h1);
    check("flag_delay", 64'(out_delay), 64'd1);
    cancel = 1'b1; in_data = 32'h55; in_exc = 4'b0100; in_delay = 1'b1;
    tick();
    check("cxl_valid", 64'(out_valid), 64'd0);
    check("cxl_data", 64'(out_data), 64'd0);
    check("cxl_exc", 64'(out_exc), 64'd0);
    check("cxl_delay", 64'(out_delay), 64'd0);
    check("cxl_allow", 64'(in_allow_in), 64'd1);
    tick();
    check("cxl_empty_valid", 64'(out_valid), 64'd0);
    check("cxl_empty_data", 64'(out_data), 64'd0);
    cancel = 1'b0; in_valid = 1'b0; in_data = '0; in_exc = '0; in_delay = 1'b0;

    // bubble saturation from 2 with CNT_W=3
    out_allow_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    check("bub_6", 64'(bubble_cnt), 64'd6);
    tick();
    check("bub_7", 64'(bubble_cnt), 64'd7);
    for (int i = 0; i < 5; i++) tick();
    check("bub_sat", 64'(bubble_cnt), 64'd7);
    cancel = 1'b1;
    tick();
    check("bub_cxl", 64'(bubble_cnt), 64'd7);
    cancel = 1'b0;

    // fill to full (TWO in skid build), then reset between edges
    out_allow_in = 1'b0; in_valid = 1'b1; in_data = 32'hC; in_exc = 4'b0010;
    tick();
    in_data = 32'hD;
    tick();
    check("full_outC", 64'(out_data), 64'hC);
    #2;
    reset = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_data", 64'(out_data), 64'd0);
    check("arst_exc", 64'(out_exc), 64'd0);
    check("arst_bub", 64'(bubble_cnt), 64'd0);
    check("arst_allow", 64'(in_allow_in), 64'd1);

    // after reset the register restarts empty and accepts at once
    #3;
    reset = 1'b1; in_data = 32'hE; in_exc = '0; out_allow_in = 1'b1;
    tick();
    check("post_outE", 64'(out_data), 64'hE);
    in_valid = 1'b0;
    tick();
    check("post_empty", 64'(out_valid), 64'd0);
    check("post_zero", 64'(out_data), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
